// File: rtl/booth_pkg.sv
// Shared encodings for the sequential radix-2 Booth multiplier: FSM states
// and the {Q[0],Q(-1)} recoding that selects add or subtract.
package booth_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   localparam logic [1:0] BOOTH_ADD = 2'b01;
   localparam logic [1:0] BOOTH_SUB = 2'b10;

endpackage

// File: rtl/booth_step_unit.sv
// One combinational radix-2 Booth step: conditional add/sub of M into ACC,
// then arithmetic right shift of {ACC,Q,Q(-1)}. Holds no state.
module booth_step_unit
   import booth_pkg::*;
#(
   parameter int W = 5
) (
   input  logic [W-1:0] acc,
   input  logic [W-1:0] q,
   input  logic         q_m1,
   input  logic [W-1:0] m,
   output logic [W-1:0] acc_nxt,
   output logic [W-1:0] q_nxt,
   output logic         q_m1_nxt
);

   logic [W-1:0] sum;

   always_comb begin
      sum = acc;
      case ({q[0], q_m1})
         BOOTH_ADD: sum = acc + m;
         BOOTH_SUB: sum = acc - m;
         default:   sum = acc;
      endcase
   end

   // Operands are pre-extended by one bit, so ACC never overflows and the
   // sign bit can be replicated safely.
   assign {acc_nxt, q_nxt, q_m1_nxt} = {sum[W-1], sum, q};

endmodule

// File: rtl/booth_mult_seq.sv
// Sequential signed/unsigned Booth multiplier, WIDTH+1 steps per operation,
// fixed latency; new starts are ignored while busy.
module booth_mult_seq
   import booth_pkg::*;
#(
   parameter int WIDTH = 4,
   parameter int CNT_W = $clog2(WIDTH + 2)
) (
   input  logic               i_clk,
   input  logic               i_rst_n,
   input  logic               i_start,
   input  logic               i_signed,
   input  logic [WIDTH-1:0]   i_multiplicand,
   input  logic [WIDTH-1:0]   i_multiplier,
   output logic [2*WIDTH-1:0] o_product,
   output logic               o_busy,
   output logic               o_done
);

   localparam int XW = WIDTH + 1;

   state_t           state;
   logic [XW-1:0]    m_reg;
   logic [XW-1:0]    acc;
   logic [XW-1:0]    q;
   logic             q_m1;
   logic [CNT_W-1:0] cnt;

   logic [XW-1:0]    acc_nxt;
   logic [XW-1:0]    q_nxt;
   logic             q_m1_nxt;
   logic [XW-1:0]    m_ext;
   logic [XW-1:0]    q_ext;

   // Extra top bit lets unsigned operands run through the signed algorithm.
   assign m_ext = {i_signed & i_multiplicand[WIDTH-1], i_multiplicand};
   assign q_ext = {i_signed & i_multiplier[WIDTH-1], i_multiplier};

   booth_step_unit #(.W(XW)) u_step (
      .acc      (acc),
      .q        (q),
      .q_m1     (q_m1),
      .m        (m_reg),
      .acc_nxt  (acc_nxt),
      .q_nxt    (q_nxt),
      .q_m1_nxt (q_m1_nxt)
   );

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state     <= ST_IDLE;
         m_reg     <= '0;
         acc       <= '0;
         q         <= '0;
         q_m1      <= 1'b0;
         cnt       <= '0;
         o_product <= '0;
         o_busy    <= 1'b0;
         o_done    <= 1'b0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (i_start) begin
                  m_reg  <= m_ext;
                  q      <= q_ext;
                  acc    <= '0;
                  q_m1   <= 1'b0;
                  cnt    <= CNT_W'(WIDTH + 1);
                  state  <= ST_RUN;
                  o_busy <= 1'b1;
               end
            end
            ST_RUN: begin
               acc  <= acc_nxt;
               q    <= q_nxt;
               q_m1 <= q_m1_nxt;
               cnt  <= cnt - CNT_W'(1);
               if (cnt == CNT_W'(1)) begin
                  o_product <= {acc_nxt[WIDTH-2:0], q_nxt};
                  o_done    <= 1'b1;
                  state     <= ST_DONE;
               end
            end
            ST_DONE: begin
               o_done <= 1'b0;
               o_busy <= 1'b0;
               state  <= ST_IDLE;
            end
            default: begin
               o_done <= 1'b0;
               o_busy <= 1'b0;
               state  <= ST_IDLE;
            end
         endcase
      end
   end

endmodule
